// File: rtl/mem_access_pkg.sv
// Shared types for the byte-addressed load/store front end.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package mem_access_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Access size as encoded on req_size_i.
    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // A request is rejected when its size is illegal or its address is not
    // a multiple of the access size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size_t'(size))
            HALF:    bad = off[0];
            WORD:    bad = (off != 2'b00);
            ILLEGAL: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte/half/word lane extraction with sign/zero extension, plus store-lane merge.
// Latency: purely combinational.
// Backpressure: none.
// Ports: word_i (word read from memory), wdata_i (right-justified store data),
//        addr_i (byte offset in word), size_i, unsigned_i -> load_o (extended
//        load value), merge_o (word_i with the addressed lane replaced by wdata_i).
module lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;
    logic              sext;

    always_comb begin
        byte_v  = word_i[{addr_i, 3'b000} +: BYTE_W];
        half_v  = word_i[{addr_i[1], 4'b0000} +: HALF_W];
        sext    = ~unsigned_i;
        load_o  = word_i;
        merge_o = word_i;
        case (size_t'(size_i))
            BYTE: begin
                load_o = {{(WORD_W-BYTE_W){sext & byte_v[BYTE_W-1]}}, byte_v};
                merge_o[{addr_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            HALF: begin
                load_o = {{(WORD_W-HALF_W){sext & half_v[HALF_W-1]}}, half_v};
                merge_o[{addr_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
            end
            WORD: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
            default: begin
                load_o  = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end driving a word-only BRAM with active-low strobes.
// Latency: load 2, word store 2, sub-word store 3 (read-modify-write), error 1 cycle to rsp_valid_o.
// Backpressure: one request in flight; req_ready_o is high only while idle.
// Ports: clk_i/reset_i (sync, active-high); req_* request channel; rsp_* one-cycle
//        response; mem_* word address, write data, active-low wr/rd strobes and read data.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WORDS      = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [WORDS+1:0]      req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    state_t                state_q, state_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WORDS-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0] load_v;
    logic [31:0] merge_v;
    logic        accept;

    // mem_data_i is valid at the edge ending a read-strobe cycle, so both the
    // load extraction and the RMW merge are taken straight from it.
    lane_align u_lane_align (
        .word_i     (mem_data_i),
        .wdata_i    (wdata_q),
        .addr_i     (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .load_o     (load_v),
        .merge_o    (merge_v)
    );

    assign accept = req_valid_i & req_ready_o;

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    size_d     = req_size_i;
                    uns_d      = req_unsigned_i;
                    off_d      = req_addr_i[1:0];
                    wdata_d    = req_wdata_i;
                    mem_addr_d = req_addr_i[WORDS+1:2];
                    if (req_bad(req_size_i, req_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else if (!req_we_i) begin
                        state_d = ST_RD;
                    end else if (size_t'(req_size_i) == WORD) begin
                        // Full-word store needs no read; present data right away.
                        mem_data_d = req_wdata_i;
                        state_d    = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = load_v;
                err_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_RMW_RD: begin
                mem_data_d = merge_v;
                state_d    = ST_RMW_WR;
            end
            ST_WR, ST_RMW_WR: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Strobes decode the registered state only, so they can never be low together
    // and both return high at the reset edge.
    assign mem_rd_o    = ~((state_q == ST_RD) || (state_q == ST_RMW_RD));
    assign mem_wr_o    = ~((state_q == ST_WR) || (state_q == ST_RMW_WR));
    assign rsp_valid_o = (state_q == ST_DONE);
    assign req_ready_o = (state_q == ST_IDLE) & ~reset_i;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

endmodule
